core_seq: RTL

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/core_seq.sv
// rtl/core_seq.sv - multi-cycle fetch/exec/mem/writeback sequencer with retire counter and sticky trap
module core_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset_,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_jump,
    input  logic             take_target,
    input  logic             regwrite_req,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [XLEN-1:0]  store_data,
    input  logic [XLEN-1:0]  pc_target,
    output logic [31:0]      instr,
    output logic [XLEN-1:0]  pc,
    output logic             reg_we,
    output logic [XLEN-1:0]  wb_data,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_TRAP  = 3'd5
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [31:0]       instr_q;
    logic [CNT_W-1:0]  instret_q;
    logic              trap_q;
    logic              imem_req_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic              reg_we_q;
    logic              retire_q;
    logic [XLEN-1:0]   wb_data_q;

    // Decode/datapath snapshot taken in EXEC; nothing after EXEC looks at the live inputs.
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   store_q;
    logic [XLEN-1:0]   target_q;
    logic              take_q;
    logic              jump_q;
    logic              rw_q;
    logic              load_q;

    logic [XLEN-1:0]   pc_plus4;
    assign pc_plus4 = pc_q + XLEN'(4);

    always_ff @(posedge clock) begin
        if (reset_) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            instret_q  <= '0;
            trap_q     <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            retire_q   <= 1'b0;
            wb_data_q  <= '0;
            alu_q      <= '0;
            store_q    <= '0;
            target_q   <= '0;
            take_q     <= 1'b0;
            jump_q     <= 1'b0;
            rw_q       <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            retire_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q    <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q    <= alu_out;
                    store_q  <= store_data;
                    target_q <= pc_target;
                    take_q   <= take_target;
                    jump_q   <= is_jump;
                    rw_q     <= regwrite_req;
                    load_q   <= is_load;
                    if (instr_q[1:0] != 2'b11) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                    end else if (take_target && (pc_target[1:0] != 2'b00)) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                    end else if (is_load || is_store) begin
                        state_q    <= S_MEM;
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= is_store;
                    end else begin
                        state_q   <= S_WB;
                        reg_we_q  <= regwrite_req;
                        retire_q  <= 1'b1;
                        wb_data_q <= is_jump ? pc_plus4 : alu_out;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        state_q    <= S_WB;
                        reg_we_q   <= rw_q;
                        retire_q   <= 1'b1;
                        wb_data_q  <= jump_q ? pc_plus4 : (load_q ? dmem_rdata : alu_q);
                    end
                end
                S_WB: begin
                    pc_q       <= take_q ? target_q : pc_plus4;
                    instret_q  <= instret_q + CNT_W'(1);
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q    <= S_TRAP;
                    trap_q     <= 1'b1;
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = store_q;
    assign instr      = instr_q;
    assign pc         = pc_q;
    assign reg_we     = reg_we_q;
    assign wb_data    = wb_data_q;
    assign retire     = retire_q;
    assign instret    = instret_q;
    assign trap       = trap_q;
    assign state      = state_q;

endmodule
